// File: rtl/vga_fb_arbiter.sv
// Framebuffer port arbiter: display reads take priority; host writes are posted
// into a small FIFO and drained on idle cycles; host reads wait until the FIFO is empty.
module vga_fb_arbiter #(
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_WIDTH = 12,
    parameter int WBUF_DEPTH = 4
) (
    input  logic                          pixel_clk,
    input  logic                          reset,
    input  logic                          disp_req,
    input  logic [ADDR_WIDTH-1:0]         disp_addr,
    output logic                          disp_rvalid,
    output logic [DATA_WIDTH-1:0]         disp_rdata,
    input  logic                          host_valid,
    input  logic                          host_we,
    input  logic [ADDR_WIDTH-1:0]         host_addr,
    input  logic [DATA_WIDTH-1:0]         host_wdata,
    output logic                          host_ready,
    output logic                          host_rvalid,
    output logic [DATA_WIDTH-1:0]         host_rdata,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    input  logic [DATA_WIDTH-1:0]         mem_rdata,
    output logic [$clog2(WBUF_DEPTH):0]   wbuf_level
);

    localparam int IW = $clog2(WBUF_DEPTH);
    localparam int PW = IW + 1;

    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_DISP,
        TAG_HOST
    } tag_t;

    logic [ADDR_WIDTH-1:0] r_buf_addr [WBUF_DEPTH];
    logic [DATA_WIDTH-1:0] r_buf_data [WBUF_DEPTH];
    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic [PW-1:0]         r_level;
    tag_t                  r_tag;
    tag_t                  w_tag_next;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;

    // Pointer MSB differs only when the write side has lapped the read side.
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[IW-1:0] == r_rptr[IW-1:0]) && (r_wptr[IW] != r_rptr[IW]);

    always_comb begin
        host_ready = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        w_push     = 1'b0;
        w_pop      = 1'b0;
        w_tag_next = TAG_NONE;
        if (!reset) begin
            // Reads wait for an empty buffer so they never overtake a posted write.
            host_ready = host_we ? !w_full : (w_empty && !disp_req);
            w_push     = host_valid && host_we && !w_full;
            if (disp_req) begin
                mem_en     = 1'b1;
                mem_addr   = disp_addr;
                w_tag_next = TAG_DISP;
            end else if (!w_empty) begin
                mem_en     = 1'b1;
                mem_we     = 1'b1;
                mem_addr   = r_buf_addr[r_rptr[IW-1:0]];
                mem_wdata  = r_buf_data[r_rptr[IW-1:0]];
                w_pop      = 1'b1;
            end else if (host_valid && !host_we) begin
                mem_en     = 1'b1;
                mem_addr   = host_addr;
                w_tag_next = TAG_HOST;
            end
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_tag   <= TAG_NONE;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + PW'(1);
            end else if (!w_push && w_pop) begin
                r_level <= r_level - PW'(1);
            end
            r_tag <= w_tag_next;
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (w_push) begin
            r_buf_addr[r_wptr[IW-1:0]] <= host_addr;
            r_buf_data[r_wptr[IW-1:0]] <= host_wdata;
        end
    end

    // The reset gate drops the return of a read issued just before reset.
    assign disp_rvalid = (r_tag == TAG_DISP) && !reset;
    assign host_rvalid = (r_tag == TAG_HOST) && !reset;
    assign disp_rdata  = mem_rdata;
    assign host_rdata  = mem_rdata;
    assign wbuf_level  = r_level;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed testbench for vga_fb_arbiter with a behavioural 1-cycle-latency RAM.
// Inputs change on the falling edge; outputs are checked just after it.
module tb_vga_fb_arbiter;

    logic        pixel_clk;
    logic        reset;
    logic        disp_req;
    logic [18:0] disp_addr;
    logic        disp_rvalid;
    logic [11:0] disp_rdata;
    logic        host_valid;
    logic        host_we;
    logic [18:0] host_addr;
    logic [11:0] host_wdata;
    logic        host_ready;
    logic        host_rvalid;
    logic [11:0] host_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [18:0] mem_addr;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata;
    logic [2:0]  wbuf_level;

    logic [11:0] ram [0:1023];
    int nChecks = 0;
    int nFails  = 0;

    vga_fb_arbiter #(.ADDR_WIDTH(19), .DATA_WIDTH(12), .WBUF_DEPTH(4)) dut (
        .pixel_clk  (pixel_clk),
        .reset      (reset),
        .disp_req   (disp_req),
        .disp_addr  (disp_addr),
        .disp_rvalid(disp_rvalid),
        .disp_rdata (disp_rdata),
        .host_valid (host_valid),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_ready (host_ready),
        .host_rvalid(host_rvalid),
        .host_rdata (host_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .wbuf_level (wbuf_level)
    );

    initial begin
        pixel_clk = 1'b0;
        forever #5 pixel_clk = ~pixel_clk;
    end

    always @(posedge pixel_clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr[9:0]] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr[9:0]];
        end
    end

    function automatic logic [11:0] fInit(input int i);
        return 12'((i * 37 + 5) % 4096);
    endfunction

    task automatic idle();
        disp_req   = 1'b0;
        disp_addr  = '0;
        host_valid = 1'b0;
        host_we    = 1'b0;
        host_addr  = '0;
        host_wdata = '0;
    endtask

    task automatic step();
        @(negedge pixel_clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        disp_req   = 1'b1;
        host_valid = 1'b1;
        host_we    = 1'b1;
        step();
        step();
        #1;
        nChecks++; if (wbuf_level !== 3'd0) begin nFails++; $display("[TB] FAIL rst_level: got %0d want 0", wbuf_level); end
        nChecks++; if (disp_rvalid !== 1'b0) begin nFails++; $display("[TB] FAIL rst_disp_rvalid: got %b want 0", disp_rvalid); end
        nChecks++; if (host_rvalid !== 1'b0) begin nFails++; $display("[TB] FAIL rst_host_rvalid: got %b want 0", host_rvalid); end
        nChecks++; if (host_ready !== 1'b0) begin nFails++; $display("[TB] FAIL rst_host_ready: got %b want 0", host_ready); end
        nChecks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin nFails++; $display("[TB] FAIL rst_mem: got en=%b we=%b want 0 0", mem_en, mem_we); end
        step();
        reset = 1'b0;
        idle();
        step();
    endtask

    task automatic test_display_only();
        for (int k = 0; k < 9; k++) begin
            step();
            idle();
            if (k < 8) begin
                disp_req  = 1'b1;
                disp_addr = 19'(k);
            end
            #1;
            if (k < 8) begin
                nChecks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 19'(k)) begin
                    nFails++; $display("[TB] FAIL disp_mem[%0d]: got en=%b we=%b addr=%0d want 1 0 %0d", k, mem_en, mem_we, mem_addr, k);
                end
            end
            nChecks++; if (disp_rvalid !== (k != 0)) begin nFails++; $display("[TB] FAIL disp_rvalid[%0d]: got %b want %b", k, disp_rvalid, k != 0); end
            if (k != 0) begin
                nChecks++; if (disp_rdata !== fInit(k - 1)) begin nFails++; $display("[TB] FAIL disp_rdata[%0d]: got %h want %h", k, disp_rdata, fInit(k - 1)); end
            end
            nChecks++; if (host_rvalid !== 1'b0) begin nFails++; $display("[TB] FAIL disp_host_rvalid[%0d]: got %b want 0", k, host_rvalid); end
        end
        step();
        #1;
        nChecks++; if (disp_rvalid !== 1'b0) begin nFails++; $display("[TB] FAIL disp_rvalid_end: got %b want 0", disp_rvalid); end
    endtask

    task automatic test_posted_write();
        step();
        idle();
        host_valid = 1'b1;
        host_we    = 1'b1;
        host_addr  = 19'd100;
        host_wdata = 12'h5A5;
        #1;
        nChecks++; if (host_ready !== 1'b1) begin nFails++; $display("[TB] FAIL pw_ready: got %b want 1", host_ready); end
        nChecks++; if (mem_en !== 1'b0) begin nFails++; $display("[TB] FAIL pw_no_bypass: got mem_en=%b want 0", mem_en); end
        step();
        idle();
        #1;
        nChecks++; if (wbuf_level !== 3'd1) begin nFails++; $display("[TB] FAIL pw_level1: got %0d want 1", wbuf_level); end
        nChecks++; if (mem_we !== 1'b1 || mem_addr !== 19'd100 || mem_wdata !== 12'h5A5) begin
            nFails++; $display("[TB] FAIL pw_drain: got we=%b addr=%0d data=%h want 1 100 5a5", mem_we, mem_addr, mem_wdata);
        end
        step();
        #1;
        nChecks++; if (wbuf_level !== 3'd0) begin nFails++; $display("[TB] FAIL pw_level0: got %0d want 0", wbuf_level); end
        nChecks++; if (ram[100] !== 12'h5A5) begin nFails++; $display("[TB] FAIL pw_ram: got %h want 5a5", ram[100]); end
    endtask

    task automatic test_buffer_full();
        int expLevel [6] = '{4, 3, 3, 2, 1, 0};
        for (int i = 0; i < 5; i++) begin
            step();
            idle();
            disp_req   = 1'b1;
            disp_addr  = 19'd50;
            host_valid = 1'b1;
            host_we    = 1'b1;
            host_addr  = 19'(200 + i);
            host_wdata = 12'(12'h100 + i);
            #1;
            nChecks++; if (host_ready !== (i < 4)) begin nFails++; $display("[TB] FAIL full_ready[%0d]: got %b want %b", i, host_ready, i < 4); end
            nChecks++; if (mem_we !== 1'b0) begin nFails++; $display("[TB] FAIL full_no_drain[%0d]: got mem_we=%b want 0", i, mem_we); end
        end
        nChecks++; if (wbuf_level !== 3'd4) begin nFails++; $display("[TB] FAIL full_level: got %0d want 4", wbuf_level); end
        for (int j = 0; j < 6; j++) begin
            step();
            disp_req = 1'b0;
            if (j >= 2) host_valid = 1'b0;
            #1;
            nChecks++; if (wbuf_level !== 3'(expLevel[j])) begin nFails++; $display("[TB] FAIL drain_level[%0d]: got %0d want %0d", j, wbuf_level, expLevel[j]); end
            if (j < 2) begin
                nChecks++; if (host_ready !== (j == 1)) begin nFails++; $display("[TB] FAIL drain_ready[%0d]: got %b want %b", j, host_ready, j == 1); end
            end
            if (j < 5) begin
                nChecks++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 19'(200 + j) || mem_wdata !== 12'(12'h100 + j)) begin
                    nFails++; $display("[TB] FAIL drain_write[%0d]: got en=%b we=%b addr=%0d data=%h want 1 1 %0d %h", j, mem_en, mem_we, mem_addr, mem_wdata, 200 + j, 12'h100 + j);
                end
            end else begin
                nChecks++; if (mem_en !== 1'b0) begin nFails++; $display("[TB] FAIL drain_idle: got mem_en=%b want 0", mem_en); end
            end
        end
    endtask

    task automatic test_read_after_write();
        step();
        idle();
        disp_req   = 1'b1;
        host_valid = 1'b1;
        host_we    = 1'b1;
        host_addr  = 19'd7;
        host_wdata = 12'h123;
        #1;
        nChecks++; if (host_ready !== 1'b1) begin nFails++; $display("[TB] FAIL raw_wr_ready: got %b want 1", host_ready); end
        step();
        host_we    = 1'b0;
        host_wdata = '0;
        #1;
        nChecks++; if (host_ready !== 1'b0) begin nFails++; $display("[TB] FAIL raw_rd_blocked_disp: got %b want 0", host_ready); end
        step();
        disp_req = 1'b0;
        #1;
        nChecks++; if (host_ready !== 1'b0) begin nFails++; $display("[TB] FAIL raw_rd_blocked_buf: got %b want 0", host_ready); end
        nChecks++; if (mem_we !== 1'b1 || mem_addr !== 19'd7) begin nFails++; $display("[TB] FAIL raw_drain: got we=%b addr=%0d want 1 7", mem_we, mem_addr); end
        step();
        #1;
        nChecks++; if (host_ready !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 19'd7) begin
            nFails++; $display("[TB] FAIL raw_rd_issue: got rdy=%b en=%b we=%b addr=%0d want 1 1 0 7", host_ready, mem_en, mem_we, mem_addr);
        end
        step();
        idle();
        #1;
        nChecks++; if (host_rvalid !== 1'b1 || host_rdata !== 12'h123) begin nFails++; $display("[TB] FAIL raw_rdata: got v=%b d=%h want 1 123", host_rvalid, host_rdata); end
        nChecks++; if (disp_rvalid !== 1'b0) begin nFails++; $display("[TB] FAIL raw_disp_rvalid: got %b want 0", disp_rvalid); end
    endtask

    task automatic test_collision();
        step();
        idle();
        disp_req   = 1'b1;
        disp_addr  = 19'd20;
        host_valid = 1'b1;
        host_addr  = 19'd30;
        #1;
        nChecks++; if (host_ready !== 1'b0 || mem_addr !== 19'd20) begin nFails++; $display("[TB] FAIL col_grant: got rdy=%b addr=%0d want 0 20", host_ready, mem_addr); end
        step();
        disp_req = 1'b0;
        #1;
        nChecks++; if (host_ready !== 1'b1 || mem_addr !== 19'd30 || mem_we !== 1'b0) begin nFails++; $display("[TB] FAIL col_host: got rdy=%b addr=%0d we=%b want 1 30 0", host_ready, mem_addr, mem_we); end
        nChecks++; if (disp_rvalid !== 1'b1 || disp_rdata !== fInit(20)) begin nFails++; $display("[TB] FAIL col_disp_data: got v=%b d=%h want 1 %h", disp_rvalid, disp_rdata, fInit(20)); end
        step();
        idle();
        #1;
        nChecks++; if (host_rvalid !== 1'b1 || host_rdata !== fInit(30)) begin nFails++; $display("[TB] FAIL col_host_data: got v=%b d=%h want 1 %h", host_rvalid, host_rdata, fInit(30)); end
        nChecks++; if (disp_rvalid !== 1'b0) begin nFails++; $display("[TB] FAIL col_disp_rvalid: got %b want 0", disp_rvalid); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            step();
            idle();
            disp_req   = 1'b1;
            disp_addr  = 19'(40 + i);
            host_valid = 1'b1;
            host_we    = 1'b1;
            host_addr  = 19'(300 + i);
            host_wdata = 12'(12'hA00 + i);
        end
        step();
        idle();
        reset = 1'b1;
        #1;
        nChecks++; if (disp_rvalid !== 1'b0) begin nFails++; $display("[TB] FAIL mid_rst_rvalid: got %b want 0", disp_rvalid); end
        nChecks++; if (mem_en !== 1'b0 || host_ready !== 1'b0) begin nFails++; $display("[TB] FAIL mid_rst_mem: got en=%b rdy=%b want 0 0", mem_en, host_ready); end
        step();
        reset = 1'b0;
        #1;
        nChecks++; if (wbuf_level !== 3'd0) begin nFails++; $display("[TB] FAIL mid_level: got %0d want 0", wbuf_level); end
        nChecks++; if (disp_rvalid !== 1'b0) begin nFails++; $display("[TB] FAIL mid_rvalid: got %b want 0", disp_rvalid); end
        for (int k = 0; k < 3; k++) begin
            nChecks++; if (mem_en !== 1'b0) begin nFails++; $display("[TB] FAIL mid_no_write[%0d]: got mem_en=%b want 0", k, mem_en); end
            step();
            #1;
        end
        for (int i = 0; i < 3; i++) begin
            nChecks++; if (ram[300 + i] !== fInit(300 + i)) begin nFails++; $display("[TB] FAIL mid_ram[%0d]: got %h want %h", 300 + i, ram[300 + i], fInit(300 + i)); end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = fInit(i);
        mem_rdata = '0;
        reset     = 1'b1;
        idle();
        test_reset();
        test_display_only();
        test_posted_write();
        test_buffer_full();
        test_read_after_write();
        test_collision();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port synchronous framebuffer RAM between two requesters: the VGA display read path and a host pixel port.
- The display read path always has priority and sees a fixed 1-cycle read latency.
- Host writes are posted into a small write buffer and drained only on cycles with no display request, so the host can write during active video without stalling scan-out.
- Sits between the pattern/pixel generator, the host logic and the framebuffer RAM, all in the pixel_clk domain.

Parameters:
- ADDR_WIDTH, 19, framebuffer word address width.
- DATA_WIDTH, 12, pixel word width (packed RGB).
- WBUF_DEPTH, 4, host write buffer entries; power of two, at least 2.

Ports:
- pixel_clk  input  1  single clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- disp_req  input  1  display read request for this cycle.
- disp_addr  input  ADDR_WIDTH  display read address.
- disp_rvalid  output  1  display read data valid; asserted 1 cycle after disp_req.
- disp_rdata  output  DATA_WIDTH  display read data.
- host_valid  input  1  host request valid.
- host_we  input  1  1 = write, 0 = read.
- host_addr  input  ADDR_WIDTH  host address.
- host_wdata  input  DATA_WIDTH  host write data.
- host_ready  output  1  host request accepted when host_valid && host_ready.
- host_rvalid  output  1  host read data valid.
- host_rdata  output  DATA_WIDTH  host read data.
- mem_en  output  1  RAM access enable.
- mem_we  output  1  RAM write enable.
- mem_addr  output  ADDR_WIDTH  RAM address.
- mem_wdata  output  DATA_WIDTH  RAM write data.
- mem_rdata  input  DATA_WIDTH  RAM read data; valid the cycle after a read.
- wbuf_level  output  $clog2(WBUF_DEPTH)+1  current write buffer occupancy.

Behaviour:
- Interface: one clock (pixel_clk); reset is synchronous and active-high (reset).
- RAM model: the RAM samples mem_en/mem_we/mem_addr/mem_wdata at the clock edge. Read data appears on mem_rdata in the next cycle.
- Grant priority, evaluated each cycle, one RAM access per cycle:
  - (1) disp_req: read disp_addr.
  - (2) else if the buffer is not empty: pop the head and write it.
  - (3) else if a host read is accepted: read host_addr.
  - (4) else mem_en=0.
- The mem_* outputs are combinational from the grant. They are forced to 0 while reset is high.
- host_ready for a write (host_we=1) = buffer not full. The write is pushed at the clock edge; it is never bypassed to the RAM in the same cycle.
- host_ready for a read (host_we=0) = buffer empty && !disp_req. The read is issued to the RAM in the acceptance cycle.
  - This rule guarantees read-after-write ordering.
  - host_ready is combinational on host_we and disp_req.
- Read return tracking: a registered source tag (NONE/DISP/HOST) records the grant type of the previous cycle.
  - disp_rvalid = (tag==DISP).
  - host_rvalid = (tag==HOST).
  - disp_rdata = host_rdata = mem_rdata; the data is meaningful only while the matching valid is high.
- Latency:
  - Display read: exactly 1 cycle, unconditionally.
  - Host read: 1 cycle after acceptance.
  - Host write: at least 1 cycle after push, extended indefinitely while disp_req is continuously high.
- Write buffer:
  - FIFO with read and write pointers of $clog2(WBUF_DEPTH)+1 bits. Pointers wrap modulo WBUF_DEPTH; the extra MSB distinguishes full from empty.
  - Push and pop can occur in the same cycle: the level is unchanged and both pointers advance.
  - A push when full cannot occur, because host_ready=0.
  - wbuf_level equals the entry count and is registered.
- disp_req held high continuously (active video) blocks all drains and host reads. The buffer fills and host writes then stall via host_ready.
- Reset values, including reset asserted mid-operation:
  - Buffer emptied, with pending writes discarded.
  - wbuf_level=0, tag=NONE, disp_rvalid=0, host_rvalid=0, host_ready=0, mem_en=0, mem_we=0.
  - A read issued in the cycle before reset asserts produces no rvalid.
- The display and host address spaces are identical; no address translation is applied.

Test Plan:
- Display only: disp_req=1 for addresses 0..7 on consecutive cycles -> mem_en=1, mem_we=0 every cycle. disp_rvalid rises 1 cycle after the first request and carries RAM[0..7] in order; host_rvalid stays 0.
- Posted write drain: with disp_req=0, host writes 0x5A5 to addr 100 -> host_ready=1, wbuf_level=1. Next cycle mem_we=1, mem_addr=100, mem_wdata=0x5A5; then wbuf_level=0.
- Buffer full under active video: disp_req=1 held, host issues 5 writes -> first 4 accepted, wbuf_level=4, host_ready=0 on the 5th. Drop disp_req -> 4 RAM writes on 4 consecutive cycles in FIFO order, during which the 5th write is accepted (a same-cycle push and pop).
- Read-after-write ordering: write 0x123 to addr 7 with disp_req=1, then host read addr 7 -> host_ready=0 on the read until disp_req falls and the buffer drains. host_rvalid then returns 0x123.
- Collision: host read valid in the same cycle as disp_req -> display granted, host_ready=0. The read is accepted on the first cycle with disp_req=0 and host_rvalid follows 1 cycle later.
- Reset mid-operation: 3 buffered writes plus an outstanding display read, then assert reset for 1 cycle -> wbuf_level=0, disp_rvalid=0. No further RAM writes occur and the RAM contents at those addresses are unchanged.
